// File: rtl/lbist_ctrl.sv
// rtl/lbist_ctrl.sv - LBIST execution engine: PRPG scan load, capture sequencing, MISR compaction
module lbist_ctrl #(
  parameter int          NUM_CHAIN = 8,
  parameter logic [31:0] PRPG_SEED = 32'hACE1_2468,
  parameter logic [31:0] MISR_SEED = 32'h0000_0000
) (
  input  logic                 mclk,
  input  logic                 reset,
  input  logic                 cfg_lbist_rst,
  input  logic                 cfg_lbist_start,
  input  logic                 cfg_lbist_rsb,
  input  logic [15:0]          cfg_lbist_pat,
  input  logic [15:0]          cfg_chain_depth,
  output logic                 scan_mode,
  output logic                 scan_en,
  output logic [NUM_CHAIN-1:0] scan_si,
  input  logic [NUM_CHAIN-1:0] scan_so,
  output logic                 lbist_done,
  output logic [31:0]          lbist_sig
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t      state, state_n;
  logic        start_d;
  logic [31:0] prpg, misr;
  logic [31:0] prpg_n, misr_n, so_ext;
  logic [15:0] pat_q, depth_q, pat_cnt, shift_cnt;
  logic        first_q;
  logic        start_edge, last_shift, load;

  assign start_edge = cfg_lbist_start & ~start_d;
  // depth_q is never zero while in SHIFT, so the subtraction cannot wrap there
  assign last_shift = (shift_cnt == depth_q - 16'd1);
  assign so_ext     = 32'(scan_so);
  assign prpg_n     = {prpg[30:0], prpg[31] ^ prpg[21] ^ prpg[1] ^ prpg[0]};
  assign misr_n     = {misr[30:0], misr[31] ^ misr[21] ^ misr[1] ^ misr[0]} ^ so_ext;
  assign scan_si    = prpg[NUM_CHAIN-1:0];
  assign lbist_sig  = misr;

  // Next-state and scan control outputs
  always_comb begin
    state_n    = state;
    load       = 1'b0;
    scan_mode  = 1'b0;
    scan_en    = 1'b0;
    lbist_done = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          load    = 1'b1;
          state_n = (cfg_lbist_pat == 16'd0 || cfg_chain_depth == 16'd0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        scan_mode = 1'b1;
        scan_en   = 1'b1;
        if (last_shift) begin
          state_n = (pat_cnt == pat_q) ? DONE : CAPTURE;
        end
      end
      CAPTURE: begin
        scan_mode = 1'b1;
        state_n   = SHIFT;
      end
      DONE: begin
        lbist_done = 1'b1;
        if (start_edge) begin
          load    = 1'b1;
          state_n = (cfg_lbist_pat == 16'd0 || cfg_chain_depth == 16'd0) ? DONE : SHIFT;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register and datapath; soft reset behaves exactly like the hard reset
  always_ff @(posedge mclk) begin
    if (reset || cfg_lbist_rst) begin
      state     <= IDLE;
      start_d   <= 1'b0;
      prpg      <= PRPG_SEED;
      misr      <= MISR_SEED;
      pat_q     <= 16'd0;
      depth_q   <= 16'd0;
      pat_cnt   <= 16'd0;
      shift_cnt <= 16'd0;
      first_q   <= 1'b0;
    end else begin
      state   <= state_n;
      start_d <= cfg_lbist_start;
      if (load) begin
        pat_q     <= cfg_lbist_pat;
        depth_q   <= cfg_chain_depth;
        prpg      <= PRPG_SEED;
        misr      <= MISR_SEED;
        pat_cnt   <= 16'd0;
        shift_cnt <= 16'd0;
        first_q   <= 1'b1;
      end else if (state == SHIFT) begin
        prpg <= prpg_n;
        // The first load shifts out pre-test flop state; rsb keeps it out of the signature
        if (!(first_q && cfg_lbist_rsb)) begin
          misr <= misr_n;
        end
        shift_cnt <= last_shift ? 16'd0 : shift_cnt + 16'd1;
      end else if (state == CAPTURE) begin
        pat_cnt <= pat_cnt + 16'd1;
        first_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lbist_ctrl.sv
// tb/tb_lbist_ctrl.sv - directed self-checking bench for lbist_ctrl
module tb_lbist_ctrl;

  localparam int          NC   = 8;
  localparam logic [31:0] PSEED = 32'hACE1_2468;
  localparam logic [31:0] MSEED = 32'h0000_0000;

  logic          mclk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_lbist_rst = 1'b0;
  logic          cfg_lbist_start = 1'b0;
  logic          cfg_lbist_rsb = 1'b0;
  logic [15:0]   cfg_lbist_pat = 16'd0;
  logic [15:0]   cfg_chain_depth = 16'd0;
  logic          scan_mode, scan_en, lbist_done;
  logic [NC-1:0] scan_si;
  logic [NC-1:0] scan_so = '0;
  logic [31:0]   lbist_sig;

  int n_cmp = 0;
  int n_err = 0;

  lbist_ctrl #(.NUM_CHAIN(NC), .PRPG_SEED(PSEED), .MISR_SEED(MSEED)) dut (
    .mclk(mclk), .reset(reset), .cfg_lbist_rst(cfg_lbist_rst),
    .cfg_lbist_start(cfg_lbist_start), .cfg_lbist_rsb(cfg_lbist_rsb),
    .cfg_lbist_pat(cfg_lbist_pat), .cfg_chain_depth(cfg_chain_depth),
    .scan_mode(scan_mode), .scan_en(scan_en), .scan_si(scan_si), .scan_so(scan_so),
    .lbist_done(lbist_done), .lbist_sig(lbist_sig)
  );

  always #5 mclk = ~mclk;

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
  endfunction

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  // Runs one start edge; cycle 0 is the cycle whose closing edge samples the edge.
  // mode: 0 zero scan_so, 1 ones during first d shifts, 2 random.
  task automatic run_lbist(input int p, input int d, input bit rsb, input int mode,
                           input int tog_cyc, input int rst_cyc,
                           output int done_cyc, output int en_cnt, output int cap_cnt,
                           output int cap1, output int cap2, output int si_err,
                           output bit done1, output logic [31:0] exp_sig);
    logic [31:0] prpg_m, misr_m;
    logic [NC-1:0] so;
    int cyc, shcnt;
    prpg_m = PSEED; misr_m = MSEED;
    done_cyc = -1; en_cnt = 0; cap_cnt = 0; cap1 = -1; cap2 = -1; si_err = 0; done1 = 1'b0;
    shcnt = 0;
    cfg_lbist_start = 1'b0;
    cfg_lbist_pat = 16'(p); cfg_chain_depth = 16'(d); cfg_lbist_rsb = rsb;
    scan_so = '0;
    tick();
    cfg_lbist_start = 1'b1;
    tick();
    cyc = 1;
    while (cyc <= 3000) begin
      if (cyc == 1) done1 = lbist_done;
      if (lbist_done) begin
        done_cyc = cyc;
        break;
      end
      if (cyc == rst_cyc) begin
        cfg_lbist_rst = 1'b1;
        cfg_lbist_start = 1'b0;
        tick();
        cfg_lbist_rst = 1'b0;
        done_cyc = 0;
        exp_sig = MSEED;
        return;
      end
      if (cyc == tog_cyc) begin
        cfg_lbist_pat = ~cfg_lbist_pat;
        cfg_chain_depth = cfg_chain_depth + 16'd3;
      end
      if (scan_en) begin
        en_cnt++;
        case (mode)
          1: so = (shcnt < d) ? '1 : '0;
          2: so = NC'($urandom);
          default: so = '0;
        endcase
        scan_so = so;
        if (scan_si !== prpg_m[NC-1:0]) si_err++;
        if (!(rsb && shcnt < d)) misr_m = lfsr_step(misr_m) ^ 32'(so);
        prpg_m = lfsr_step(prpg_m);
        shcnt++;
      end else begin
        scan_so = '0;
        if (scan_mode) begin
          cap_cnt++;
          if (cap1 < 0) cap1 = cyc; else cap2 = cyc;
        end
      end
      tick();
      cyc++;
    end
    exp_sig = misr_m;
  endtask

  task automatic test_reset();
    reset = 1'b1; cfg_lbist_start = 1'b0;
    repeat (3) tick();
    n_cmp++; if (scan_mode !== 1'b0) begin n_err++; $display("FAIL reset_scan_mode got %b want 0", scan_mode); end
    n_cmp++; if (scan_en !== 1'b0) begin n_err++; $display("FAIL reset_scan_en got %b want 0", scan_en); end
    n_cmp++; if (lbist_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", lbist_done); end
    n_cmp++; if (lbist_sig !== MSEED) begin n_err++; $display("FAIL reset_sig got %h want %h", lbist_sig, MSEED); end
    n_cmp++; if (scan_si !== PSEED[NC-1:0]) begin n_err++; $display("FAIL reset_si got %h want %h", scan_si, PSEED[NC-1:0]); end
    reset = 1'b0;
    repeat (2) tick();
    n_cmp++; if (scan_en !== 1'b0 || lbist_done !== 1'b0) begin n_err++; $display("FAIL idle_quiet got en=%b done=%b want 0/0", scan_en, lbist_done); end
    // start held high through reset: no run during reset, edge seen right after release
    reset = 1'b1; cfg_lbist_pat = 16'd2; cfg_chain_depth = 16'd4; cfg_lbist_start = 1'b1;
    repeat (2) tick();
    n_cmp++; if (scan_en !== 1'b0) begin n_err++; $display("FAIL held_start_in_reset got en=%b want 0", scan_en); end
    reset = 1'b0;
    tick();
    n_cmp++; if (scan_en !== 1'b1) begin n_err++; $display("FAIL start_after_release got en=%b want 1", scan_en); end
    cfg_lbist_rst = 1'b1; cfg_lbist_start = 1'b0;
    tick();
    cfg_lbist_rst = 1'b0;
  endtask

  task automatic test_basic();
    int dc, en, cc, c1, c2, se; bit d1; logic [31:0] es;
    run_lbist(2, 4, 1'b0, 0, -1, -1, dc, en, cc, c1, c2, se, d1, es);
    n_cmp++; if (dc !== 15) begin n_err++; $display("FAIL basic_done_cycle got %0d want 15", dc); end
    n_cmp++; if (en !== 12) begin n_err++; $display("FAIL basic_scan_en_cycles got %0d want 12", en); end
    n_cmp++; if (cc !== 2) begin n_err++; $display("FAIL basic_capture_count got %0d want 2", cc); end
    n_cmp++; if (c1 !== 5 || c2 !== 10) begin n_err++; $display("FAIL basic_capture_cycles got %0d,%0d want 5,10", c1, c2); end
    n_cmp++; if (se !== 0) begin n_err++; $display("FAIL basic_scan_si got %0d bad cycles want 0", se); end
    n_cmp++; if (lbist_sig !== es) begin n_err++; $display("FAIL basic_sig got %h want %h", lbist_sig, es); end
    repeat (3) tick();
    n_cmp++; if (lbist_done !== 1'b1 || scan_en !== 1'b0) begin n_err++; $display("FAIL held_start_no_restart got done=%b en=%b want 1/0", lbist_done, scan_en); end
  endtask

  task automatic test_rsb();
    int dc, en, cc, c1, c2, se; bit d1; logic [31:0] es, sig_zero, sig_a;
    run_lbist(2, 4, 1'b1, 0, -1, -1, dc, en, cc, c1, c2, se, d1, es);
    sig_zero = lbist_sig;
    n_cmp++; if (sig_zero !== es) begin n_err++; $display("FAIL rsb_zero_sig got %h want %h", sig_zero, es); end
    run_lbist(2, 4, 1'b1, 1, -1, -1, dc, en, cc, c1, c2, se, d1, es);
    sig_a = lbist_sig;
    n_cmp++; if (sig_a !== sig_zero) begin n_err++; $display("FAIL rsb_excludes_first got %h want %h", sig_a, sig_zero); end
    n_cmp++; if (sig_a !== es) begin n_err++; $display("FAIL rsb_model_sig got %h want %h", sig_a, es); end
    run_lbist(2, 4, 1'b0, 1, -1, -1, dc, en, cc, c1, c2, se, d1, es);
    n_cmp++; if (lbist_sig !== es) begin n_err++; $display("FAIL no_rsb_sig got %h want %h", lbist_sig, es); end
    n_cmp++; if (lbist_sig === sig_zero) begin n_err++; $display("FAIL no_rsb_differs got %h want not %h", lbist_sig, sig_zero); end
  endtask

  task automatic test_zero_cfg();
    int dc, en, cc, c1, c2, se; bit d1; logic [31:0] es;
    run_lbist(0, 4, 1'b0, 2, -1, -1, dc, en, cc, c1, c2, se, d1, es);
    n_cmp++; if (dc !== 1 || en !== 0) begin n_err++; $display("FAIL p0_timing got done=%0d en=%0d want 1/0", dc, en); end
    n_cmp++; if (lbist_sig !== MSEED) begin n_err++; $display("FAIL p0_sig got %h want %h", lbist_sig, MSEED); end
    run_lbist(2, 0, 1'b0, 2, -1, -1, dc, en, cc, c1, c2, se, d1, es);
    n_cmp++; if (dc !== 1 || en !== 0) begin n_err++; $display("FAIL d0_timing got done=%0d en=%0d want 1/0", dc, en); end
    n_cmp++; if (lbist_sig !== MSEED) begin n_err++; $display("FAIL d0_sig got %h want %h", lbist_sig, MSEED); end
  endtask

  task automatic test_soft_reset();
    int dc, en, cc, c1, c2, se; bit d1; logic [31:0] es;
    run_lbist(3, 8, 1'b0, 2, -1, 12, dc, en, cc, c1, c2, se, d1, es);
    n_cmp++; if (dc !== 0) begin n_err++; $display("FAIL srst_reached got %0d want 0", dc); end
    n_cmp++; if (scan_en !== 1'b0 || scan_mode !== 1'b0 || lbist_done !== 1'b0) begin
      n_err++; $display("FAIL srst_outputs got en=%b mode=%b done=%b want 0/0/0", scan_en, scan_mode, lbist_done); end
    n_cmp++; if (lbist_sig !== MSEED) begin n_err++; $display("FAIL srst_sig got %h want %h", lbist_sig, MSEED); end
    run_lbist(3, 8, 1'b0, 2, -1, -1, dc, en, cc, c1, c2, se, d1, es);
    n_cmp++; if (dc !== 36) begin n_err++; $display("FAIL srst_rerun_cycle got %0d want 36", dc); end
    n_cmp++; if (lbist_sig !== es) begin n_err++; $display("FAIL srst_rerun_sig got %h want %h", lbist_sig, es); end
  endtask

  task automatic test_back_to_back();
    int dc, en, cc, c1, c2, se; bit d1; logic [31:0] es;
    run_lbist(2, 4, 1'b0, 2, -1, -1, dc, en, cc, c1, c2, se, d1, es);
    n_cmp++; if (dc !== 15 || lbist_sig !== es) begin n_err++; $display("FAIL b2b_first got cyc=%0d sig=%h want 15/%h", dc, lbist_sig, es); end
    run_lbist(2, 4, 1'b0, 2, 3, -1, dc, en, cc, c1, c2, se, d1, es);
    n_cmp++; if (d1 !== 1'b0) begin n_err++; $display("FAIL b2b_done_drop got %b want 0", d1); end
    n_cmp++; if (dc !== 15) begin n_err++; $display("FAIL b2b_cfg_change_cycle got %0d want 15", dc); end
    n_cmp++; if (se !== 0) begin n_err++; $display("FAIL b2b_reseed_si got %0d bad cycles want 0", se); end
    n_cmp++; if (lbist_sig !== es) begin n_err++; $display("FAIL b2b_sig got %h want %h", lbist_sig, es); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rsb();
    test_zero_cfg();
    test_soft_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
